// File: rtl/fwd_hazard_tracker.sv
// Forwarding/hazard unit: shadows in-flight destination registers, drives EX forward selects,
// decode-stage hazard stall and decode branch bypass. Optional build macro: FWD_R0_HARDWIRED_EN.
module fwd_hazard_tracker #(
    parameter int REG_AW   = 4,
    parameter int NSRC     = 2,
    parameter int NSTAGE   = 3,
    parameter int LOAD_RDY = 3,
    parameter int SELW     = $clog2(NSTAGE + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   id_valid,
    input  logic [NSRC*REG_AW-1:0] id_src,
    input  logic [NSRC-1:0]        id_src_use,
    input  logic                   id_wr,
    input  logic [REG_AW-1:0]      id_rd,
    input  logic                   id_load,
    input  logic                   id_branch,
    input  logic                   pipe_stall,
    input  logic                   flush,
    output logic                   hazard_stall,
    output logic [NSRC-1:0]        id_br_fwd,
    output logic [NSRC*SELW-1:0]   ex_fwd_sel
);
    // Entry k shadows the destination of the instruction k stages past decode.
    logic [NSTAGE:1]      e_v;
    logic [NSTAGE:1]      e_ld;
    logic [REG_AW-1:0]    e_rd [1:NSTAGE];

    logic [NSTAGE:1]      match [NSRC];
    logic [NSRC-1:0]      last_hit;
    logic [NSRC-1:0]      near_hit;
    logic                 load_use;
    logic [NSRC*SELW-1:0] pred_sel;
    logic                 enter;

    always_comb begin
        last_hit = '0;
        for (int s = 0; s < NSRC; s++) begin
            match[s] = '0;
            for (int k = 1; k <= NSTAGE; k++) begin
                match[s][k] = e_v[k] && id_src_use[s] &&
                              (e_rd[k] == id_src[s*REG_AW +: REG_AW]);
`ifdef FWD_R0_HARDWIRED_EN
                if (id_src[s*REG_AW +: REG_AW] == '0) match[s][k] = 1'b0;
`endif
            end
            last_hit[s] = match[s][NSTAGE];
        end
    end

    // Walk from oldest forwardable stage to youngest so the youngest producer wins.
    always_comb begin
        load_use = 1'b0;
        near_hit = '0;
        pred_sel = '0;
        for (int s = 0; s < NSRC; s++) begin
            for (int k = NSTAGE - 1; k >= 1; k--) begin
                if (match[s][k]) begin
                    near_hit[s]              = 1'b1;
                    pred_sel[s*SELW +: SELW] = SELW'(k + 1);
                    if (e_ld[k] && (k + 1 < LOAD_RDY)) load_use = 1'b1;
                end
            end
        end
    end

    assign hazard_stall = id_valid && !flush && (id_branch ? (|near_hit) : load_use);
    assign id_br_fwd    = {NSRC{id_branch}} & last_hit & ~near_hit;
    assign enter        = id_valid && !flush && !hazard_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_v        <= '0;
            e_ld       <= '0;
            ex_fwd_sel <= '0;
            for (int k = 1; k <= NSTAGE; k++) e_rd[k] <= '0;
        end else if (!pipe_stall) begin
            for (int k = 2; k <= NSTAGE; k++) begin
                e_v[k]  <= e_v[k-1];
                e_ld[k] <= e_ld[k-1];
                e_rd[k] <= e_rd[k-1];
            end
            // Non-writers and bubbles enter as invalid entries; rd is don't-care then.
            e_v[1]     <= enter && id_wr;
            e_ld[1]    <= enter && id_wr && id_load;
            e_rd[1]    <= id_rd;
            ex_fwd_sel <= enter ? pred_sel : '0;
        end
    end
endmodule

// File: tb/tb_fwd_hazard_tracker.sv
// Self-checking bench for fwd_hazard_tracker: directed instruction sequences, expected EX selects
// queued per decode cycle and compared after the clock edge; honours FWD_R0_HARDWIRED_EN.
module tb_fwd_hazard_tracker;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       id_valid = 1'b0;
    logic [7:0] id_src = '0;
    logic [1:0] id_src_use = '0;
    logic       id_wr = 1'b0;
    logic [3:0] id_rd = '0;
    logic       id_load = 1'b0;
    logic       id_branch = 1'b0;
    logic       pipe_stall = 1'b0;
    logic       flush = 1'b0;
    logic       hazard_stall;
    logic [1:0] id_br_fwd;
    logic [3:0] ex_fwd_sel;

    int total = 0;
    int bad = 0;
    logic [3:0] exp_q[$];

    fwd_hazard_tracker dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_src(id_src),
        .id_src_use(id_src_use), .id_wr(id_wr), .id_rd(id_rd), .id_load(id_load),
        .id_branch(id_branch), .pipe_stall(pipe_stall), .flush(flush),
        .hazard_stall(hazard_stall), .id_br_fwd(id_br_fwd), .ex_fwd_sel(ex_fwd_sel)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One decode cycle: drive, check combinational outputs mid-cycle, queue the
    // expected EX select, then compare it once the edge has produced it.
    task automatic cyc(input string tag, input logic v, input logic [3:0] s1, input logic [3:0] s0,
                       input logic [1:0] su, input logic wr, input logic [3:0] rd, input logic ld,
                       input logic br, input logic ps, input logic fl,
                       input logic ehz, input logic [1:0] ebr, input logic [3:0] esel);
        logic [3:0] exp_sel;
        id_valid = v; id_src = {s1, s0}; id_src_use = su; id_wr = wr; id_rd = rd;
        id_load = ld; id_branch = br; pipe_stall = ps; flush = fl;
        @(negedge clk);
        check_eq({tag, "_hz"}, 32'(hazard_stall), 32'(ehz));
        check_eq({tag, "_br"}, 32'(id_br_fwd), 32'(ebr));
        exp_q.push_back(esel);
        @(posedge clk);
        #1;
        exp_sel = exp_q.pop_front();
        check_eq({tag, "_sel"}, 32'(ex_fwd_sel), 32'(exp_sel));
    endtask

    // Bubble with random don't-care fields; must never create a producer.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            cyc("idle", 1'b0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 2'b00,
                1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1'b0, 1'b0, 1'b0, 1'b0,
                1'b0, 2'b00, 4'b0000);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_hz", 32'(hazard_stall), 0);
        check_eq("rst_br", 32'(id_br_fwd), 0);
        check_eq("rst_sel", 32'(ex_fwd_sel), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // ALU to ALU: forward from EX/MEM.
        cyc("a_add3", 1, 0, 0, 2'b00, 1, 3, 0, 0, 0, 0, 0, 2'b00, 4'b0000);
        cyc("a_use3", 1, 1, 3, 2'b01, 1, 6, 0, 0, 0, 0, 0, 2'b00, 4'b0010);
        idle(3);

        // Load-use: one stall cycle, then forward from MEM/WB on operand 1.
        cyc("b_lw5", 1, 0, 0, 2'b00, 1, 5, 1, 0, 0, 0, 0, 2'b00, 4'b0000);
        cyc("b_stall", 1, 5, 1, 2'b10, 1, 7, 0, 0, 0, 0, 1, 2'b00, 4'b0000);
        cyc("b_go", 1, 5, 1, 2'b10, 1, 7, 0, 0, 0, 0, 0, 2'b00, 4'b1100);
        idle(3);

        // Two producers of r2: the youngest wins on both operands.
        cyc("c_p1", 1, 0, 0, 2'b00, 1, 2, 0, 0, 0, 0, 0, 2'b00, 4'b0000);
        cyc("c_p2", 1, 0, 0, 2'b00, 1, 2, 0, 0, 0, 0, 0, 2'b00, 4'b0000);
        cyc("c_use", 1, 2, 2, 2'b11, 1, 8, 0, 0, 0, 0, 0, 2'b00, 4'b1010);
        idle(3);

        // Branch after ALU: two stall cycles, then bypass from MEM/WB.
        cyc("d_add4", 1, 0, 0, 2'b00, 1, 4, 0, 0, 0, 0, 0, 2'b00, 4'b0000);
        cyc("d_st1", 1, 0, 4, 2'b01, 0, 0, 0, 1, 0, 0, 1, 2'b00, 4'b0000);
        cyc("d_st2", 1, 0, 4, 2'b01, 0, 0, 0, 1, 0, 0, 1, 2'b00, 4'b0000);
        cyc("d_byp", 1, 0, 4, 2'b01, 0, 0, 0, 1, 0, 0, 0, 2'b01, 4'b0000);
        idle(3);

        // Pipeline freeze: entries and select hold, sequence resumes.
        cyc("e_add9", 1, 0, 0, 2'b00, 1, 9, 0, 0, 0, 0, 0, 2'b00, 4'b0000);
        cyc("e_add10", 1, 0, 9, 2'b01, 1, 10, 0, 0, 0, 0, 0, 2'b00, 4'b0010);
        for (int i = 0; i < 3; i++)
            cyc("e_frz", 1, 10, 9, 2'b11, 1, 11, 0, 0, 1, 0, 0, 2'b00, 4'b0010);
        cyc("e_res", 1, 10, 9, 2'b11, 1, 11, 0, 0, 0, 0, 0, 2'b00, 4'b1011);
        idle(3);

        // Flush beats a load-use hazard and lets a bubble in.
        cyc("f_lw5", 1, 0, 0, 2'b00, 1, 5, 1, 0, 0, 0, 0, 2'b00, 4'b0000);
        cyc("f_flush", 1, 0, 5, 2'b01, 1, 7, 0, 0, 0, 1, 0, 2'b00, 4'b0000);
        cyc("f_go", 1, 0, 5, 2'b01, 1, 7, 0, 0, 0, 0, 0, 2'b00, 4'b0011);
        idle(3);

        // Register 0 producer.
        cyc("g_lw0", 1, 0, 0, 2'b00, 1, 0, 1, 0, 0, 0, 0, 2'b00, 4'b0000);
`ifdef FWD_R0_HARDWIRED_EN
        cyc("g_use0", 1, 1, 0, 2'b01, 1, 7, 0, 0, 0, 0, 0, 2'b00, 4'b0000);
        cyc("g_use0b", 1, 1, 0, 2'b01, 1, 7, 0, 0, 0, 0, 0, 2'b00, 4'b0000);
`else
        cyc("g_stall0", 1, 1, 0, 2'b01, 1, 7, 0, 0, 0, 0, 1, 2'b00, 4'b0000);
        cyc("g_use0", 1, 1, 0, 2'b01, 1, 7, 0, 0, 0, 0, 0, 2'b00, 4'b0011);
`endif
        idle(3);

        // Hazard stays live during a freeze; async reset clears everything mid-freeze.
        cyc("h_add9", 1, 0, 0, 2'b00, 1, 9, 0, 0, 0, 0, 0, 2'b00, 4'b0000);
        cyc("h_lw5", 1, 0, 9, 2'b01, 1, 5, 1, 0, 0, 0, 0, 2'b00, 4'b0010);
        cyc("h_frz", 1, 0, 5, 2'b01, 1, 7, 0, 0, 1, 0, 1, 2'b00, 4'b0010);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("h_rst_hz", 32'(hazard_stall), 0);
        check_eq("h_rst_br", 32'(id_br_fwd), 0);
        check_eq("h_rst_sel", 32'(ex_fwd_sel), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cyc("h_after", 1, 0, 5, 2'b01, 1, 7, 0, 0, 0, 0, 0, 2'b00, 4'b0000);
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
